mux_scan_nx1: RTL and testbench
===============================

# mux_scan_nx1

Parametrised, registered N-to-1 channel multiplexer, the successor to the dataflow 4x1 vector mux. It is generalised to N channels of W bits each. It has two operating modes:
- **Manual:** an external select chooses the channel.
- **Scan:** an internal pointer steps through the channels, holding each one for DWELL cycles.

The output is registered and carries a valid flag, the channel tag, and a wrap pulse. It sits between a multi-channel source bank and a single-channel consumer, such as a serial monitor or a shared datapath.

## Interface
Parameters:
- N, 4, number of channels (N >= 2, need not be a power of two)
- W, 1, bits per channel (W >= 1)
- DWELL, 1, cycles each channel is held in scan mode (DWELL >= 1)
- SW (localparam), clog2(N), select and pointer width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  enable; 0 pauses the block
- mode  in  1  0 = manual, 1 = scan
- sel  in  SW  manual channel select
- i  in  N*W  packed inputs; channel k occupies i[k*W+W-1 : k*W]
- y  out  W  registered selected channel data
- y_ch  out  SW  channel index that y came from
- y_valid  out  1  y/y_ch were updated from a legal channel in the last cycle
- wrap  out  1  one-cycle pulse on the last dwell cycle of channel N-1 in scan mode

## Operation
- Reset, asynchronous and immediate: y=0, y_ch=0, y_valid=0, wrap=0, scan pointer ptr=0, dwell counter cnt=0.
- The FSM has three states, re-evaluated every cycle from en/mode:
  - IDLE when en=0.
  - MAN when en=1 and mode=0.
  - SCAN when en=1 and mode=1.
- Any state may go to any other in a single cycle.
- **IDLE:**
  - y and y_ch hold.
  - y_valid=0 and wrap=0.
  - ptr holds; cnt is cleared to 0.
- **MAN:**
  - Legal sel (sel < N): y <= channel sel, y_ch <= sel, y_valid <= 1.
  - Illegal sel (sel >= N, only possible when N is not a power of two): y and y_ch hold, y_valid <= 0.
  - wrap=0.
  - ptr is untouched; cnt is cleared to 0.
- **SCAN:**
  - Each cycle: y <= channel ptr, y_ch <= ptr, y_valid <= 1.
  - If cnt == DWELL-1: cnt <= 0, and ptr <= ptr+1, wrapping N-1 -> 0.
  - Otherwise cnt <= cnt+1.
  - wrap <= (ptr == N-1 && cnt == DWELL-1).
- Scan entry from IDLE or MAN resumes at the held ptr with a fresh dwell (cnt=0).
- The ptr wrap is explicit at N-1. This matters when N is not a power of two: ptr never reaches an illegal value.
- The counter width is clog2(DWELL), with a minimum of 1. With DWELL=1 the pointer advances every cycle.

## Timing
- Latency is 1 cycle: i/sel/mode/en sampled at edge t appear on y/y_ch/y_valid/wrap after edge t.
- There is no combinational path from any input to any output.
- In scan, each channel is presented for exactly DWELL consecutive cycles. The full rotation period is N*DWELL cycles while en=1 and mode=1.
- wrap is high for exactly one cycle per rotation, coincident with the final y_ch=N-1 cycle.
- A change of i within a dwell window is tracked cycle-by-cycle: y follows the live channel data with 1-cycle latency and is not latched at dwell start.
- Simultaneous events:
  - rst dominates everything.
  - If en falls at the same time as the dwell boundary, the pause takes priority: ptr does not advance, and cnt is cleared.
- If rst is asserted mid-scan, outputs go to 0 without waiting for a clock edge. After release, the first enabled scan cycle presents channel 0.

## Test plan
1. **Async reset mid-scan.** N=4, DWELL=2, scan running at ptr=2; assert rst between clock edges -> y, y_ch, y_valid and wrap are 0 immediately. After release with en=1 and mode=1, the first y_ch is 0.
2. **Manual one-hot.** N=4, W=1, en=1, mode=0. Apply sel=0,1,2,3 with i=4'b0001, 4'b0010, 4'b0100, 4'b1000 respectively, 1 cycle each -> y=1 and y_ch=sel one cycle later, y_valid=1 throughout. Then sel=1 with i=4'b1101 -> y=0.
3. **Scan with dwell.** N=4, W=1, DWELL=2, i=4'b1010, scan from reset:
   - y_ch = 0,0,1,1,2,2,3,3,0,0
   - y = 0,0,1,1,0,0,1,1,0,0
   - wrap=1 only on the second y_ch=3 cycle.
4. **Pause.** Scan N=4, DWELL=3; drop en for 3 cycles while y_ch=2 (mid-dwell) -> y_valid=0, y_ch stays 2, wrap=0. On en=1, y_ch=2 for 3 full cycles, then 3.
5. **Non-power-of-two.** N=3, W=8, i={8'hA5, 8'h3C, 8'h0F}:
   - Manual sel=3 -> y_valid=0, y holds its prior value.
   - Manual sel=2 -> y=8'hA5.
   - Scan with DWELL=1 -> y = 0F, 3C, A5, 0F, with wrap on the A5 cycle.
6. **Mode switch.** Scan N=4, DWELL=1, stopped in MAN when ptr=1; in MAN, sel=3 -> y_ch=3. On switching back to scan -> y_ch = 1, 2, 3, 0, and ptr is unaffected by sel.

Source files
------------

// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 channel multiplexer with manual select and dwell-timed scan modes.
// Outputs carry the source channel tag, a valid flag and a once-per-rotation wrap pulse.
module mux_scan_nx1 #(
   parameter  int unsigned N     = 4,
   parameter  int unsigned W     = 1,
   parameter  int unsigned DWELL = 1,
   localparam int unsigned SW    = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   input  logic [N*W-1:0] i,
   output logic [W-1:0]   y,
   output logic [SW-1:0]  y_ch,
   output logic           y_valid,
   output logic           wrap
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

   state_t         state, state_d;
   logic [SW-1:0]  ptr, ptr_d;
   logic [CW-1:0]  cnt, cnt_d, cnt_cur;
   logic [W-1:0]   y_d;
   logic [SW-1:0]  y_ch_d;
   logic           y_valid_d, wrap_d;
   logic           sel_legal;
   logic [W-1:0]   ch [N];

   for (genvar k = 0; k < N; k++) begin : g_ch
      assign ch[k] = i[k*W +: W];
   end

   // Only reachable when N is not a power of two.
   assign sel_legal = (32'(sel) < N);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         cnt     <= '0;
         y       <= '0;
         y_ch    <= '0;
         y_valid <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         state   <= state_d;
         ptr     <= ptr_d;
         cnt     <= cnt_d;
         y       <= y_d;
         y_ch    <= y_ch_d;
         y_valid <= y_valid_d;
         wrap    <= wrap_d;
      end
   end

   // State is decided from en/mode each cycle; actions follow the state being entered.
   always_comb begin
      state_d   = IDLE;
      ptr_d     = ptr;
      cnt_d     = '0;
      y_d       = y;
      y_ch_d    = y_ch;
      y_valid_d = 1'b0;
      wrap_d    = 1'b0;
      // A scan entered from another state always starts a fresh dwell.
      cnt_cur   = (state == SCAN) ? cnt : '0;

      if (en) state_d = mode ? SCAN : MAN;

      case (state_d)
         MAN: begin
            if (sel_legal) begin
               y_d       = ch[sel];
               y_ch_d    = sel;
               y_valid_d = 1'b1;
            end
         end
         SCAN: begin
            y_d       = ch[ptr];
            y_ch_d    = ptr;
            y_valid_d = 1'b1;
            wrap_d    = (ptr == PTR_LAST) && (cnt_cur == CNT_LAST);
            if (cnt_cur == CNT_LAST) begin
               cnt_d = '0;
               ptr_d = (ptr == PTR_LAST) ? '0 : ptr + SW'(1);
            end else begin
               cnt_d = cnt_cur + CW'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed self-checking bench for mux_scan_nx1 across four parameter sets.
`timescale 1ns/1ps
module tb_mux_scan_nx1;

   int total = 0;
   int bad   = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // a: N=4 W=1 DWELL=2
   logic a_en = 0, a_mode = 0; logic [1:0] a_sel = 0; logic [3:0] a_i = 0;
   logic [0:0] a_y; logic [1:0] a_ych; logic a_v, a_w;
   // b: N=4 W=1 DWELL=3
   logic b_en = 0, b_mode = 0; logic [1:0] b_sel = 0; logic [3:0] b_i = 0;
   logic [0:0] b_y; logic [1:0] b_ych; logic b_v, b_w;
   // c: N=3 W=8 DWELL=1
   logic c_en = 0, c_mode = 0; logic [1:0] c_sel = 0; logic [23:0] c_i = 0;
   logic [7:0] c_y; logic [1:0] c_ych; logic c_v, c_w;
   // d: N=4 W=1 DWELL=1
   logic d_en = 0, d_mode = 0; logic [1:0] d_sel = 0; logic [3:0] d_i = 0;
   logic [0:0] d_y; logic [1:0] d_ych; logic d_v, d_w;

   mux_scan_nx1 #(.N(4), .W(1), .DWELL(2)) u_a (
      .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .sel(a_sel), .i(a_i),
      .y(a_y), .y_ch(a_ych), .y_valid(a_v), .wrap(a_w));
   mux_scan_nx1 #(.N(4), .W(1), .DWELL(3)) u_b (
      .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .sel(b_sel), .i(b_i),
      .y(b_y), .y_ch(b_ych), .y_valid(b_v), .wrap(b_w));
   mux_scan_nx1 #(.N(3), .W(8), .DWELL(1)) u_c (
      .clk(clk), .rst(rst), .en(c_en), .mode(c_mode), .sel(c_sel), .i(c_i),
      .y(c_y), .y_ch(c_ych), .y_valid(c_v), .wrap(c_w));
   mux_scan_nx1 #(.N(4), .W(1), .DWELL(1)) u_d (
      .clk(clk), .rst(rst), .en(d_en), .mode(d_mode), .sel(d_sel), .i(d_i),
      .y(d_y), .y_ch(d_ych), .y_valid(d_v), .wrap(d_w));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      #3 rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({a_y, a_ych, a_v, a_w} !== 5'b0) begin
         bad++; $display("FAIL reset_a: got %b want 00000", {a_y, a_ych, a_v, a_w});
      end
      total++;
      if ({c_y, c_ych, c_v, c_w} !== 12'b0) begin
         bad++; $display("FAIL reset_c: got %h want 000", {c_y, c_ych, c_v, c_w});
      end
      #3 rst = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      a_i = 4'b1111; a_en = 1; a_mode = 1;
      repeat (5) step();
      total++;
      if ({a_y, a_ych, a_v} !== 4'b1_10_1) begin
         bad++; $display("FAIL async_pre: y,ch,v got %b want 1101", {a_y, a_ych, a_v});
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({a_y, a_ych, a_v, a_w} !== 5'b0) begin
         bad++; $display("FAIL async_immediate: got %b want 00000", {a_y, a_ych, a_v, a_w});
      end
      #2 rst = 1'b0;
      step();
      total++;
      if ({a_y, a_ych, a_v} !== 4'b1_00_1) begin
         bad++; $display("FAIL async_first_ch: y,ch,v got %b want 1001", {a_y, a_ych, a_v});
      end
   endtask

   task automatic test_manual_onehot();
      do_reset();
      a_en = 1; a_mode = 0;
      for (int k = 0; k < 4; k++) begin
         a_sel = 2'(k);
         a_i   = 4'(1 << k);
         step();
         total++;
         if ({a_y, a_ych, a_v, a_w} !== {1'b1, 2'(k), 1'b1, 1'b0}) begin
            bad++; $display("FAIL manual_sel%0d: got %b want %b", k,
                            {a_y, a_ych, a_v, a_w}, {1'b1, 2'(k), 1'b1, 1'b0});
         end
      end
      a_sel = 2'd1; a_i = 4'b1101;
      step();
      total++;
      if ({a_y, a_ych, a_v} !== 4'b0_01_1) begin
         bad++; $display("FAIL manual_zero: got %b want 0011", {a_y, a_ych, a_v});
      end
   endtask

   task automatic test_scan_dwell();
      int exp_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      int exp_y  [10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
      do_reset();
      a_i = 4'b1010; a_en = 1; a_mode = 1;
      for (int k = 0; k < 10; k++) begin
         step();
         total++;
         if ({a_y, a_ych, a_v, a_w} !== {1'(exp_y[k]), 2'(exp_ch[k]), 1'b1, (k == 7)}) begin
            bad++; $display("FAIL scan_dwell_%0d: y,ch,v,wrap got %b want %b", k,
                            {a_y, a_ych, a_v, a_w},
                            {1'(exp_y[k]), 2'(exp_ch[k]), 1'b1, (k == 7)});
         end
      end
   endtask

   task automatic test_pause();
      int exp_ch [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
      do_reset();
      b_i = 4'b0100; b_en = 1; b_mode = 1;
      for (int k = 0; k < 7; k++) step();
      total++;
      if (b_ych !== 2'(exp_ch[6])) begin
         bad++; $display("FAIL pause_pre: ch got %0d want 2", b_ych);
      end
      b_en = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if ({b_ych, b_v, b_w} !== 4'b10_0_0) begin
            bad++; $display("FAIL pause_idle_%0d: ch,v,wrap got %b want 1000", k, {b_ych, b_v, b_w});
         end
      end
      b_en = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         total++;
         if ({b_ych, b_v} !== {((k < 3) ? 2'd2 : 2'd3), 1'b1}) begin
            bad++; $display("FAIL pause_resume_%0d: ch,v got %b want %b", k,
                            {b_ych, b_v}, {((k < 3) ? 2'd2 : 2'd3), 1'b1});
         end
      end
   endtask

   task automatic test_non_pow2();
      logic [7:0] exp_y [4] = '{8'h0F, 8'h3C, 8'hA5, 8'h0F};
      do_reset();
      c_i = {8'hA5, 8'h3C, 8'h0F}; c_en = 1; c_mode = 0; c_sel = 2'd1;
      step();
      total++;
      if ({c_y, c_ych, c_v} !== {8'h3C, 2'd1, 1'b1}) begin
         bad++; $display("FAIL np2_sel1: got %h want %h", {c_y, c_ych, c_v}, {8'h3C, 2'd1, 1'b1});
      end
      c_sel = 2'd3;
      step();
      total++;
      if ({c_y, c_ych, c_v} !== {8'h3C, 2'd1, 1'b0}) begin
         bad++; $display("FAIL np2_illegal: got %h want %h", {c_y, c_ych, c_v}, {8'h3C, 2'd1, 1'b0});
      end
      c_sel = 2'd2;
      step();
      total++;
      if ({c_y, c_ych, c_v} !== {8'hA5, 2'd2, 1'b1}) begin
         bad++; $display("FAIL np2_sel2: got %h want %h", {c_y, c_ych, c_v}, {8'hA5, 2'd2, 1'b1});
      end
      c_mode = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         total++;
         if ({c_y, c_ych, c_v, c_w} !== {exp_y[k], 2'(k % 3), 1'b1, (k == 2)}) begin
            bad++; $display("FAIL np2_scan_%0d: got %h want %h", k,
                            {c_y, c_ych, c_v, c_w}, {exp_y[k], 2'(k % 3), 1'b1, (k == 2)});
         end
      end
   endtask

   task automatic test_mode_switch();
      int exp_ch [4] = '{1, 2, 3, 0};
      do_reset();
      d_i = 4'b0110; d_en = 1; d_mode = 1; d_sel = 2'd0;
      step();
      total++;
      if ({d_ych, d_v} !== 3'b00_1) begin
         bad++; $display("FAIL mode_scan0: ch,v got %b want 001", {d_ych, d_v});
      end
      d_mode = 0; d_sel = 2'd3;
      step();
      total++;
      if ({d_y, d_ych, d_v, d_w} !== 5'b0_11_1_0) begin
         bad++; $display("FAIL mode_man3: got %b want 01110", {d_y, d_ych, d_v, d_w});
      end
      d_mode = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         total++;
         if ({d_y, d_ych, d_v, d_w} !== {d_i[exp_ch[k]], 2'(exp_ch[k]), 1'b1, (k == 2)}) begin
            bad++; $display("FAIL mode_resume_%0d: got %b want %b", k,
                            {d_y, d_ych, d_v, d_w}, {d_i[exp_ch[k]], 2'(exp_ch[k]), 1'b1, (k == 2)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_manual_onehot();
      test_scan_dwell();
      test_pause();
      test_non_pow2();
      test_mode_switch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
